// File: rtl/pipeline_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_mem_pkg
// Brief    : Shared types and constants for the pipeline memory stage.
// Revision : 1.0
// ============================================================================
package pipeline_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_R_REQ = 3'd1,
    ST_W_REQ = 3'd2,
    ST_WB    = 3'd3,
    ST_ERR   = 3'd4
  } mem_state_e;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } mem_size_e;

  localparam logic [3:0] c_BYTES_BYTE   = 4'd1;
  localparam logic [3:0] c_BYTES_HALF   = 4'd2;
  localparam logic [3:0] c_BYTES_WORD   = 4'd4;
  localparam logic [3:0] c_BYTES_DOUBLE = 4'd8;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] n;
    case (size)
      SZ_BYTE: n = c_BYTES_BYTE;
      SZ_HALF: n = c_BYTES_HALF;
      SZ_WORD: n = c_BYTES_WORD;
      default: n = c_BYTES_DOUBLE;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_load_align
// Brief    : Extracts a little-endian load from a read line and extends it.
// Revision : 1.0
// ============================================================================
module mem_load_align
  import pipeline_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int BUFFER_SIZE = 512
) (
  input  logic [BUFFER_SIZE-1:0]         line,
  input  logic [$clog2(BUFFER_SIZE/8)-1:0] offset,
  input  logic [1:0]                     size,
  input  logic                           is_unsigned,
  output logic [DATA_WIDTH-1:0]          data
);

  logic [DATA_WIDTH-1:0] w_win;
  logic [DATA_WIDTH-1:0] w_word_ext;
  logic                  w_sign_b;
  logic                  w_sign_h;
  logic                  w_sign_w;

  assign w_win    = DATA_WIDTH'(line >> {offset, 3'b000});
  assign w_sign_b = w_win[7]  & ~is_unsigned;
  assign w_sign_h = w_win[15] & ~is_unsigned;
  assign w_sign_w = w_win[31] & ~is_unsigned;

  // A word already fills a 32-bit register, so it needs no extension there.
  generate
    if (DATA_WIDTH > 32) begin : g_word_ext
      assign w_word_ext = {{(DATA_WIDTH-32){w_sign_w}}, w_win[31:0]};
    end else begin : g_word_full
      assign w_word_ext = w_win;
    end
  endgenerate

  always_comb begin
    data = w_win;
    case (size)
      SZ_BYTE: data = {{(DATA_WIDTH-8){w_sign_b}}, w_win[7:0]};
      SZ_HALF: data = {{(DATA_WIDTH-16){w_sign_h}}, w_win[15:0]};
      SZ_WORD: data = w_word_ext;
      default: data = w_win;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_mem_stage
// Brief    : Memory stage: line-based loads, lane-shifted stores, writeback.
// Revision : 1.0
// ============================================================================
module pipeline_mem_stage
  import pipeline_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BUFFER_SIZE = 512
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   ex_res,
  input  logic [DATA_WIDTH-1:0]   r2_val,
  input  logic [4:0]              dst_reg,
  input  logic [1:0]              mem_op,
  input  logic [1:0]              mem_size,
  input  logic                    mem_unsigned,
  output logic                    wb_enable,
  output logic [4:0]              wb_dst_reg,
  output logic [DATA_WIDTH-1:0]   wb_dst_val,
  output logic                    misalign,
  output logic [ADDR_WIDTH-1:0]   S_R_ADDR,
  output logic                    S_R_ADDR_VALID,
  input  logic [BUFFER_SIZE-1:0]  S_R_DATA,
  input  logic                    S_R_DATA_VALID,
  output logic [ADDR_WIDTH-1:0]   S_W_ADDR,
  output logic [DATA_WIDTH-1:0]   S_W_DATA,
  output logic [DATA_WIDTH/8-1:0] S_W_STRB,
  output logic                    S_W_VALID,
  input  logic                    S_W_READY
);

  localparam int c_STRB_W     = DATA_WIDTH / 8;
  localparam int c_LINE_OFF_W = $clog2(BUFFER_SIZE / 8);
  localparam int c_WORD_OFF_W = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] c_LINE_MASK = ~ADDR_WIDTH'(BUFFER_SIZE / 8 - 1);
  localparam logic [ADDR_WIDTH-1:0] c_WORD_MASK = ~ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  mem_state_e            r_state;
  mem_state_e            w_state_nxt;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_ex;
  logic [DATA_WIDTH-1:0] r_r2;
  logic [4:0]            r_dst;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [DATA_WIDTH-1:0] r_wb_val;

  logic                  w_accept;
  logic [2:0]            w_low_mask;
  logic                  w_misalign;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_store_mask;
  logic [c_STRB_W-1:0]   w_strb_base;
  logic [c_WORD_OFF_W-1:0] w_word_off;
  logic                  w_rd_done;

  assign w_accept   = in_valid && in_ready;
  assign w_low_mask = 3'(size_bytes(mem_size) - 4'd1);
  assign w_misalign = ((ex_res[2:0] & w_low_mask) != 3'd0) ||
                      ((mem_size == SZ_DOUBLE) && (DATA_WIDTH == 32));
  assign w_rd_done  = (r_state == ST_R_REQ) && S_R_DATA_VALID;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (mem_op == OP_LOAD)
            w_state_nxt = w_misalign ? ST_ERR : ST_R_REQ;
          else if (mem_op == OP_STORE)
            w_state_nxt = w_misalign ? ST_ERR : ST_W_REQ;
          else
            w_state_nxt = ST_WB;
        end
      end
      ST_R_REQ: if (S_R_DATA_VALID) w_state_nxt = ST_WB;
      ST_W_REQ: if (S_W_READY)      w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // r_run keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_run    <= 1'b0;
      r_ex     <= '0;
      r_r2     <= '0;
      r_dst    <= '0;
      r_size   <= '0;
      r_uns    <= 1'b0;
      r_wb_val <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_accept) begin
        r_ex     <= ex_res;
        r_r2     <= r2_val;
        r_dst    <= dst_reg;
        r_size   <= mem_size;
        r_uns    <= mem_unsigned;
        r_wb_val <= ex_res;
      end else if (w_rd_done) begin
        r_wb_val <= w_load_data;
      end
    end
  end

  generate
    if (ADDR_WIDTH > DATA_WIDTH) begin : g_addr_wide
      assign w_addr = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, r_ex};
    end else if (ADDR_WIDTH == DATA_WIDTH) begin : g_addr_equal
      assign w_addr = r_ex;
    end else begin : g_addr_narrow
      assign w_addr = r_ex[ADDR_WIDTH-1:0];
    end
  endgenerate

  mem_load_align #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_SIZE (BUFFER_SIZE)
  ) u_load_align (
    .line        (S_R_DATA),
    .offset      (r_ex[c_LINE_OFF_W-1:0]),
    .size        (r_size),
    .is_unsigned (r_uns),
    .data        (w_load_data)
  );

  assign w_word_off = r_ex[c_WORD_OFF_W-1:0];

  always_comb begin
    w_store_mask = '1;
    w_strb_base  = '1;
    case (r_size)
      SZ_BYTE: begin
        w_store_mask = DATA_WIDTH'(64'h0000_0000_0000_00FF);
        w_strb_base  = c_STRB_W'(8'h01);
      end
      SZ_HALF: begin
        w_store_mask = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
        w_strb_base  = c_STRB_W'(8'h03);
      end
      SZ_WORD: begin
        w_store_mask = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
        w_strb_base  = c_STRB_W'(8'h0F);
      end
      default: begin
        w_store_mask = '1;
        w_strb_base  = '1;
      end
    endcase
  end

  // Bus and writeback outputs are zero outside their owning state.
  assign in_ready       = r_run && (r_state == ST_IDLE);
  assign misalign       = (r_state == ST_ERR);

  assign S_R_ADDR_VALID = (r_state == ST_R_REQ);
  assign S_R_ADDR       = S_R_ADDR_VALID ? (w_addr & c_LINE_MASK) : '0;

  assign S_W_VALID      = (r_state == ST_W_REQ);
  assign S_W_ADDR       = S_W_VALID ? (w_addr & c_WORD_MASK) : '0;
  assign S_W_DATA       = S_W_VALID ? ((r_r2 & w_store_mask) << {w_word_off, 3'b000}) : '0;
  assign S_W_STRB       = S_W_VALID ? (w_strb_base << w_word_off) : '0;

  assign wb_enable      = (r_state == ST_WB) && (r_dst != 5'd0);
  assign wb_dst_reg     = wb_enable ? r_dst : 5'd0;
  assign wb_dst_val     = wb_enable ? r_wb_val : '0;

endmodule
`default_nettype wire
